axis_packer_n: RTL and testbench

//  Parametrised AXI-Stream width packer: gathers k narrow input beats (k = 1..MAX_PACK)

---
 rtl/axis_packer_n_if.sv | 26 ++
 rtl/axis_packer_n.sv | 104 ++++++++++
 tb/tb_axis_packer_n.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_packer_n_if.sv
// Stream bundle for axis_packer_n: narrow s_axis input beats and wide m_axis output words.
// master = packer side (drives s_axis_tready and m_axis_*), slave = environment side.
interface axis_packer_n_if #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_PACK   = 4
);
  logic [DATA_WIDTH-1:0]          s_axis_tdata;
  logic                           s_axis_tvalid;
  logic                           s_axis_tready;
  logic                           s_axis_tlast;
  logic [DATA_WIDTH*MAX_PACK-1:0] m_axis_tdata;
  logic [MAX_PACK-1:0]            m_axis_tkeep;
  logic                           m_axis_tvalid;
  logic                           m_axis_tready;
  logic                           m_axis_tlast;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/axis_packer_n.sv
// AXI-Stream width packer: gathers k narrow beats per output word, flushing partial words on tlast.
// Define PACK_MSB_FIRST_EN to place the first beat in the most significant lane.
module axis_packer_n #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_PACK   = 4,
  parameter int K_WIDTH    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [K_WIDTH-1:0] k,
  output logic               k_err,
  axis_packer_n_if.master    bus
);

`ifdef PACK_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  localparam logic [K_WIDTH-1:0] K_ONE = K_WIDTH'(1);
  localparam logic [K_WIDTH-1:0] K_MAX = K_WIDTH'(MAX_PACK);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                         state, state_next;
  logic [K_WIDTH-1:0]             k_q, cnt, k_clamped, k_eff;
  logic                           k_illegal, s_ready, accept, complete;
  logic [DATA_WIDTH-1:0]          acc [MAX_PACK];
  logic [DATA_WIDTH*MAX_PACK-1:0] word_next, out_data;
  logic [MAX_PACK-1:0]            keep_next, out_keep;
  logic                           out_valid, out_last;

  function automatic int beat_of_lane(input int lane);
    return MSB_FIRST ? (MAX_PACK - 1 - lane) : lane;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) state_next = bus.s_axis_tlast ? IDLE : ACCUM;
  end

  // Pack factor is taken live from the port only on a packet's first beat.
  always_comb begin
    k_illegal = (k == '0) || (k > K_MAX);
    k_clamped = k_illegal ? K_MAX : k;
    k_eff     = (state == IDLE) ? k_clamped : k_q;
    accept    = bus.s_axis_tvalid && s_ready;
    complete  = accept && (((cnt + K_ONE) == k_eff) || bus.s_axis_tlast);
    word_next = '0;
    keep_next = '0;
    for (int j = 0; j < MAX_PACK; j++) begin
      word_next[j*DATA_WIDTH +: DATA_WIDTH] =
        (K_WIDTH'(beat_of_lane(j)) == cnt) ? bus.s_axis_tdata : acc[j];
      keep_next[j] = (K_WIDTH'(beat_of_lane(j)) <= cnt);
    end
  end

  assign s_ready            = !out_valid || bus.m_axis_tready;
  assign bus.s_axis_tready  = s_ready;
  assign bus.m_axis_tdata   = out_data;
  assign bus.m_axis_tkeep   = out_keep;
  assign bus.m_axis_tvalid  = out_valid;
  assign bus.m_axis_tlast   = out_last;

  // Accumulator lanes are cleared after every emitted word so unused lanes read back as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q       <= '0;
      cnt       <= '0;
      k_err     <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int j = 0; j < MAX_PACK; j++) acc[j] <= '0;
    end else begin
      k_err <= accept && (state == IDLE) && k_illegal;
      if (accept && (state == IDLE)) k_q <= k_clamped;
      if (complete) begin
        cnt       <= '0;
        out_data  <= word_next;
        out_keep  <= keep_next;
        out_last  <= bus.s_axis_tlast;
        out_valid <= 1'b1;
        for (int j = 0; j < MAX_PACK; j++) acc[j] <= '0;
      end else begin
        if (accept) begin
          cnt <= cnt + K_ONE;
          for (int j = 0; j < MAX_PACK; j++) begin
            if (K_WIDTH'(beat_of_lane(j)) == cnt) acc[j] <= bus.s_axis_tdata;
          end
        end
        if (bus.m_axis_tready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_packer_n.sv
// Self-checking bench for axis_packer_n: directed scenarios plus randomized packets against a chunking model.
module tb_axis_packer_n;
  localparam int DW = 8;
  localparam int MP = 4;
  localparam int KW = 4;
  localparam int WW = 1 + MP + DW*MP;
  typedef logic [WW-1:0] word_t;

`ifdef PACK_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
  localparam logic [DW*MP-1:0] FIRST_K4 = 32'h00010203;
`else
  localparam bit MSB = 1'b0;
  localparam logic [DW*MP-1:0] FIRST_K4 = 32'h03020100;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [KW-1:0] k = '0;
  logic          k_err;

  axis_packer_n_if #(.DATA_WIDTH(DW), .MAX_PACK(MP)) bus ();

  axis_packer_n #(.DATA_WIDTH(DW), .MAX_PACK(MP), .K_WIDTH(KW)) dut (
    .clk(clk), .reset_n(reset_n), .k(k), .k_err(k_err), .bus(bus)
  );

  always #5 clk = ~clk;

  int              checks = 0;
  int              errors = 0;
  int              kerr_cnt = 0;
  int              stall_cnt = 0;
  bit              sink_rand = 1'b0;
  bit              sink_hold = 1'b0;
  word_t           exp_q[$];
  word_t           got_q[$];
  logic [DW-1:0]   pkt[$];

  // Monitor records every accepted output word and counts k_err pulses and input stalls.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.m_axis_tvalid && bus.m_axis_tready)
        got_q.push_back({bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata});
      if (k_err) kerr_cnt++;
      if (bus.s_axis_tvalid && !bus.s_axis_tready) stall_cnt++;
    end
  end

  initial begin
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.m_axis_tready = sink_hold ? 1'b0 : (sink_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic fill_counter(input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(DW'(i));
  endtask

  // Reference: cut the packet into chunks of the clamped k; the final chunk may be short.
  task automatic model_packet(input int kv);
    int kk, b, lane;
    logic [DW*MP-1:0] d;
    logic [MP-1:0]    kp;
    kk = (kv == 0 || kv > MP) ? MP : kv;
    for (int s = 0; s < pkt.size(); s += kk) begin
      b  = (pkt.size() - s < kk) ? pkt.size() - s : kk;
      d  = '0;
      kp = '0;
      for (int j = 0; j < b; j++) begin
        lane = MSB ? (MP - 1 - j) : j;
        d[lane*DW +: DW] = pkt[s+j];
        kp[lane] = 1'b1;
      end
      exp_q.push_back({((s + b) == pkt.size()), kp, d});
    end
  endtask

  task automatic drive_packet(input int k_first, input int k_rest, input int gap_max, input bit with_last);
    int w;
    for (int i = 0; i < pkt.size(); i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          bus.s_axis_tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = pkt[i];
      bus.s_axis_tlast  = with_last && (i == pkt.size() - 1);
      k = KW'((i == 0) ? k_first : k_rest);
      w = 0;
      @(negedge clk);
      while (!bus.s_axis_tready && w < 300) begin
        w++;
        @(negedge clk);
      end
      if (w >= 300) begin
        checks++;
        errors++;
        $display("[TB] FAIL beat_accept_timeout: beat %0d never accepted", i);
      end
      @(posedge clk);
      #1;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int t = 0; t < limit && got_q.size() < exp_q.size(); t++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic start_test;
    exp_q.delete();
    got_q.delete();
    kerr_cnt  = 0;
    stall_cnt = 0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_tvalid: got %b need 0", bus.m_axis_tvalid); end
    checks++; if (bus.m_axis_tdata !== '0) begin errors++; $display("[TB] FAIL rst_tdata: got %h need 0", bus.m_axis_tdata); end
    checks++; if (bus.m_axis_tkeep !== '0) begin errors++; $display("[TB] FAIL rst_tkeep: got %b need 0", bus.m_axis_tkeep); end
    checks++; if (bus.m_axis_tlast !== 1'b0) begin errors++; $display("[TB] FAIL rst_tlast: got %b need 0", bus.m_axis_tlast); end
    checks++; if (k_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_kerr: got %b need 0", k_err); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.s_axis_tready !== 1'b1) begin errors++; $display("[TB] FAIL rst_tready: got %b need 1", bus.s_axis_tready); end
  endtask

  task automatic test_k4;
    start_test();
    fill_counter(20);
    model_packet(4);
    drive_packet(4, 4, 0, 1'b1);
    drain(100);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL k4_count: got %0d need %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL k4_word%0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]); end
    end
    checks++; if (got_q.size() == 0 || got_q[0][DW*MP-1:0] !== FIRST_K4) begin errors++; $display("[TB] FAIL k4_first: got %h need %h", (got_q.size() > 0) ? got_q[0][DW*MP-1:0] : 'x, FIRST_K4); end
    checks++; if (stall_cnt !== 0) begin errors++; $display("[TB] FAIL k4_stalls: got %0d need 0", stall_cnt); end
  endtask

  task automatic test_k3;
    start_test();
    fill_counter(20);
    model_packet(3);
    drive_packet(3, 3, 0, 1'b1);
    drain(100);
    checks++; if (got_q.size() !== 7) begin errors++; $display("[TB] FAIL k3_count: got %0d need 7", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL k3_word%0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]); end
    end
  endtask

  task automatic test_k1;
    start_test();
    fill_counter(20);
    model_packet(1);
    drive_packet(1, 2, 0, 1'b1);
    fill_counter(4);
    model_packet(2);
    drive_packet(2, 2, 0, 1'b1);
    drain(100);
    checks++; if (got_q.size() !== 22) begin errors++; $display("[TB] FAIL k1_count: got %0d need 22", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL k1_word%0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]); end
    end
    checks++; if (stall_cnt !== 0) begin errors++; $display("[TB] FAIL k1_stalls: got %0d need 0", stall_cnt); end
  endtask

  task automatic test_backpressure;
    int w;
    logic [DW*MP-1:0] held;
    start_test();
    fill_counter(20);
    model_packet(4);
    fork
      drive_packet(4, 4, 0, 1'b1);
      begin
        w = 0;
        while (!bus.m_axis_tvalid && w < 100) begin w++; @(posedge clk); #1; end
        sink_hold = 1'b1;
        @(negedge clk);
        held = bus.m_axis_tdata;
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("[TB] FAIL bp_tready%0d: got %b need 0", c, bus.s_axis_tready); end
          checks++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== held) begin errors++; $display("[TB] FAIL bp_hold%0d: got %b/%h need 1/%h", c, bus.m_axis_tvalid, bus.m_axis_tdata, held); end
        end
        @(posedge clk);
        #1;
        sink_hold = 1'b0;
      end
    join
    drain(100);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL bp_count: got %0d need %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL bp_word%0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]); end
    end
  endtask

  task automatic test_illegal_k;
    int kvals[3] = '{0, 7, 5};
    for (int p = 0; p < 3; p++) begin
      start_test();
      fill_counter(20);
      model_packet(kvals[p]);
      drive_packet(kvals[p], kvals[p], 0, 1'b1);
      drain(100);
      checks++; if (kerr_cnt !== 1) begin errors++; $display("[TB] FAIL kerr_k%0d: got %0d pulses need 1", kvals[p], kerr_cnt); end
      checks++; if (got_q.size() !== 5) begin errors++; $display("[TB] FAIL illegal_count_k%0d: got %0d need 5", kvals[p], got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL illegal_k%0d_word%0d: got %h need %h", kvals[p], i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    start_test();
    fill_counter(2);
    drive_packet(4, 4, 0, 1'b0);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tvalid: got %b need 0", bus.m_axis_tvalid); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (got_q.size() !== 0) begin errors++; $display("[TB] FAIL midrst_output: got %0d words need 0", got_q.size()); end
    fill_counter(20);
    model_packet(4);
    drive_packet(4, 4, 0, 1'b1);
    drain(100);
    checks++; if (got_q.size() == 0 || got_q[0][DW*MP-1:0] !== FIRST_K4) begin errors++; $display("[TB] FAIL midrst_first: got %h need %h", (got_q.size() > 0) ? got_q[0][DW*MP-1:0] : 'x, FIRST_K4); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL midrst_word%0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]); end
    end
  endtask

  task automatic test_random;
    int kv, len, exp_kerr;
    start_test();
    exp_kerr  = 0;
    sink_rand = 1'b1;
    for (int p = 0; p < 10; p++) begin
      kv  = $urandom_range(0, 15);
      len = $urandom_range(1, 11);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(DW'($urandom));
      model_packet(kv);
      if (kv == 0 || kv > MP) exp_kerr++;
      drive_packet(kv, $urandom_range(0, 15), 2, 1'b1);
    end
    drain(500);
    sink_rand = 1'b0;
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("[TB] FAIL rand_count: got %0d need %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rand_word%0d: got %h need %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]); end
    end
    checks++; if (kerr_cnt !== exp_kerr) begin errors++; $display("[TB] FAIL rand_kerr: got %0d need %0d", kerr_cnt, exp_kerr); end
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    test_reset();
    test_k4();
    test_k3();
    test_k1();
    test_backpressure();
    test_illegal_k();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
